// File: rtl/anb_pkg.sv
// Shared ANB splitter definitions: page size, in-page segment length and splitter FSM states.
// The write splitter imports the same package.
package anb_pkg;

  localparam int ANB_PAGE_SIZE = 4096;
  localparam int ANB_PAGE_BITS = $clog2(ANB_PAGE_SIZE);

  typedef logic [ANB_PAGE_BITS:0] seg_len_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } rd_state_t;

  // One bit wider than the in-page offset, so an aligned address yields a full page.
  function automatic seg_len_t seg_len(input logic [ANB_PAGE_BITS-1:0] inpage_addr);
    return seg_len_t'(ANB_PAGE_SIZE) - seg_len_t'(inpage_addr);
  endfunction

endpackage

// File: rtl/anb_rd_seg_fifo_m.sv
// In-order FIFO of 1-bit "final segment" markers, one per issued read segment.
// Push is dropped when full and pop when empty; no bypass between the two.
module anb_rd_seg_fifo_m
  import anb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_din,
  input  logic          i_pop,
  output logic          o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/anb_rd_splitter_m.sv
// ANB read splitter: cuts each request into page-bounded segments and merges their data back
// into one stream whose only last flag is on the final beat of the final segment.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | accepting a new upstream request (m_a.aready high)
//   ST_ISSUE | presenting segments of the current request until the final one handshakes
module anb_rd_splitter_m
  import anb_pkg::*;
#(
  parameter type ADDR_T    = logic [31:0],
  parameter type LEN_T     = logic [31:0],
  parameter type DATA_T    = logic [127:0],
  parameter int  PAGE_SIZE = ANB_PAGE_SIZE,
  parameter int  MAX_OUTST = 8
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_m_a_avalid,
  output logic  o_m_a_aready,
  input  ADDR_T i_m_a_addr,
  input  LEN_T  i_m_a_len,
  output logic  o_s_a_avalid,
  input  logic  i_s_a_aready,
  output ADDR_T o_s_a_addr,
  output LEN_T  o_s_a_len,
  input  logic  i_s_d_valid,
  output logic  o_s_d_ready,
  input  DATA_T i_s_d_data,
  input  logic  i_s_d_last,
  output logic  o_m_d_valid,
  input  logic  i_m_d_ready,
  output DATA_T o_m_d_data,
  output logic  o_m_d_last
);

  localparam int            PW       = $clog2(PAGE_SIZE);
  localparam int            CW       = $clog2(MAX_OUTST + 1);
  localparam logic [PW:0]   PAGE_LEN = PAGE_SIZE[PW:0];
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);

  rd_state_t     r_state;
  ADDR_T         r_cur_addr;
  LEN_T          r_rlen;

  logic [PW:0]   w_room;
  LEN_T          w_seg;
  logic          w_final;
  logic          w_sa_hs;
  logic          w_ma_hs;
  logic          w_pop;
  logic          w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  assign w_room  = PAGE_LEN - {1'b0, r_cur_addr[PW-1:0]};
  assign w_seg   = (r_rlen < LEN_T'(w_room)) ? r_rlen : LEN_T'(w_room);
  assign w_final = (r_rlen == w_seg);

  assign o_m_a_aready = (r_state == ST_IDLE) & ~i_rst;
  assign o_s_a_avalid = (r_state == ST_ISSUE) & ~w_fifo_full;
  assign o_s_a_addr   = r_cur_addr;
  assign o_s_a_len    = w_seg;

  assign w_ma_hs = i_m_a_avalid & o_m_a_aready;
  assign w_sa_hs = o_s_a_avalid & i_s_a_aready;

  // Data is passed straight through; only the final segment's last beat keeps its last flag.
  assign o_m_d_valid = i_s_d_valid & ~w_fifo_empty;
  assign o_s_d_ready = i_m_d_ready & ~w_fifo_empty;
  assign o_m_d_data  = i_s_d_data;
  assign o_m_d_last  = i_s_d_last & w_fifo_head;
  assign w_pop       = i_s_d_valid & o_s_d_ready & i_s_d_last;

  anb_rd_seg_fifo_m #(
    .DEPTH (MAX_OUTST)
  ) u_seg_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_sa_hs),
    .i_din   (w_final),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_rlen     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ma_hs) begin
            r_cur_addr <= i_m_a_addr;
            r_rlen     <= i_m_a_len;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_sa_hs) begin
            r_cur_addr <= r_cur_addr + ADDR_T'(w_seg);
            r_rlen     <= r_rlen - w_seg;
            if (w_final) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Protocol guards: zero-length requests and data arriving ahead of any issued segment.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_ma_hs) assert (i_m_a_len != '0) else $error("anb_rd_splitter_m: zero-length request");
      if (i_s_d_valid) assert (!w_fifo_empty) else $error("anb_rd_splitter_m: read data with no segment outstanding");
      assert (w_fifo_count <= CNT_MAX) else $error("anb_rd_splitter_m: segment FIFO overrun");
    end
  end

endmodule

// File: tb/tb_anb_rd_splitter_m.sv
// Bench for anb_rd_splitter_m: directed and random requests checked against a request-level
// page-split model; a background responder returns data for every segment actually issued.
module tb_anb_rd_splitter_m;

  localparam int PAGE = 4096;
  localparam int BEAT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_m_a_avalid;
  logic         o_m_a_aready;
  logic [31:0]  i_m_a_addr;
  logic [31:0]  i_m_a_len;
  logic         o_s_a_avalid;
  logic         i_s_a_aready;
  logic [31:0]  o_s_a_addr;
  logic [31:0]  o_s_a_len;
  logic         i_s_d_valid;
  logic         o_s_d_ready;
  logic [127:0] i_s_d_data;
  logic         i_s_d_last;
  logic         o_m_d_valid;
  logic         i_m_d_ready;
  logic [127:0] o_m_d_data;
  logic         o_m_d_last;

  always #5 clk = ~clk;

  anb_rd_splitter_m #(
    .ADDR_T    (logic [31:0]),
    .LEN_T     (logic [31:0]),
    .DATA_T    (logic [127:0]),
    .PAGE_SIZE (PAGE),
    .MAX_OUTST (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_m_a_avalid (i_m_a_avalid),
    .o_m_a_aready (o_m_a_aready),
    .i_m_a_addr   (i_m_a_addr),
    .i_m_a_len    (i_m_a_len),
    .o_s_a_avalid (o_s_a_avalid),
    .i_s_a_aready (i_s_a_aready),
    .o_s_a_addr   (o_s_a_addr),
    .o_s_a_len    (o_s_a_len),
    .i_s_d_valid  (i_s_d_valid),
    .o_s_d_ready  (o_s_d_ready),
    .i_s_d_data   (i_s_d_data),
    .i_s_d_last   (i_s_d_last),
    .o_m_d_valid  (o_m_d_valid),
    .i_m_d_ready  (i_m_d_ready),
    .o_m_d_data   (o_m_d_data),
    .o_m_d_last   (o_m_d_last)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ma_cyc   = 0;
  int exp_idx  = 0;
  int sd_idx   = 0;
  int beat     = 0;

  logic [63:0]  q_exp_seg[$];
  logic         q_exp_last[$];
  logic [63:0]  q_seg_obs[$];
  int           q_seg_cyc[$];
  logic [127:0] q_md_data[$];
  logic         q_md_last[$];
  int           q_md_cyc[$];
  int           q_resp[$];

  bit          sd_en, sd_gap, md_rand, sa_rand, sa_force, sd_hs, prev_stall;
  logic [31:0] prev_addr, prev_len;

  function automatic logic [127:0] make_data(input int idx);
    logic [31:0] v;
    v = idx;
    return {v, ~v, v ^ 32'h5A5A_C3C3, 32'hBEEF_0000 + v};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the request in page-bounded pieces; data beats carry last only at the very end.
  task automatic add_req(input logic [31:0] addr, input logic [31:0] len);
    logic [31:0] a, r, room, seg;
    int nb;
    a = addr;
    r = len;
    while (r != 0) begin
      room = PAGE - (a % PAGE);
      seg  = (r < room) ? r : room;
      q_exp_seg.push_back({a, seg});
      a = a + seg;
      r = r - seg;
    end
    nb = len / BEAT;
    for (int i = 0; i < nb; i++) q_exp_last.push_back(i == nb - 1);
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [31:0] len);
    int n;
    n = 0;
    @(posedge clk); #1;
    i_m_a_avalid = 1'b1;
    i_m_a_addr   = addr;
    i_m_a_len    = len;
    do begin
      @(negedge clk);
      n++;
    end while (!o_m_a_aready && n < 20000);
    chk("ma_accept", o_m_a_aready, 1'b1);
    ma_cyc = cyc;
    add_req(addr, len);
    @(posedge clk); #1;
    i_m_a_avalid = 1'b0;
  endtask

  task automatic finish_phase(input string tag);
    int n, ns, nb;
    n = 0;
    while ((q_md_data.size() < q_exp_last.size() || q_seg_obs.size() < q_exp_seg.size()) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_nseg"}, q_seg_obs.size(), q_exp_seg.size());
    ns = (q_seg_obs.size() < q_exp_seg.size()) ? q_seg_obs.size() : q_exp_seg.size();
    for (int i = 0; i < ns; i++) chk({tag, "_seg"}, q_seg_obs[i], q_exp_seg[i]);
    chk({tag, "_nbeat"}, q_md_data.size(), q_exp_last.size());
    nb = (q_md_data.size() < q_exp_last.size()) ? q_md_data.size() : q_exp_last.size();
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_data"}, q_md_data[i], make_data(exp_idx + i));
      chk({tag, "_last"}, q_md_last[i], q_exp_last[i]);
    end
    exp_idx += q_md_data.size();
  endtask

  task automatic clear_obs();
    q_exp_seg.delete();
    q_exp_last.delete();
    q_seg_obs.delete();
    q_seg_cyc.delete();
    q_md_data.delete();
    q_md_last.delete();
    q_md_cyc.delete();
  endtask

  // Samples at negedge; drives downstream responder and ready inputs just after posedge.
  task automatic bg();
    forever begin
      @(negedge clk);
      if (rst) begin
        q_resp.delete();
        beat       = 0;
        prev_stall = 0;
        sd_hs      = 0;
      end else begin
        if (prev_stall) begin
          chk("sa_stall_valid", o_s_a_avalid, 1'b1);
          chk("sa_stall_addr", o_s_a_addr, prev_addr);
          chk("sa_stall_len", o_s_a_len, prev_len);
        end
        prev_stall = o_s_a_avalid && !i_s_a_aready;
        prev_addr  = o_s_a_addr;
        prev_len   = o_s_a_len;
        if (o_s_a_avalid && i_s_a_aready) begin
          q_seg_obs.push_back({o_s_a_addr, o_s_a_len});
          q_seg_cyc.push_back(cyc);
          q_resp.push_back(int'(o_s_a_len) / BEAT);
        end
        if (o_m_d_valid && i_m_d_ready) begin
          q_md_data.push_back(o_m_d_data);
          q_md_last.push_back(o_m_d_last);
          q_md_cyc.push_back(cyc);
        end
        sd_hs = i_s_d_valid && o_s_d_ready;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (sd_hs && q_resp.size() > 0) begin
        sd_idx++;
        beat++;
        if (beat >= q_resp[0]) begin
          void'(q_resp.pop_front());
          beat = 0;
        end
      end
      if (q_resp.size() == 0) begin
        i_s_d_valid = 1'b0;
      end else if (!(i_s_d_valid && !sd_hs)) begin
        if (sd_en && (!sd_gap || $urandom_range(0, 3) != 0)) begin
          i_s_d_valid = 1'b1;
          i_s_d_data  = make_data(sd_idx);
          i_s_d_last  = (beat == q_resp[0] - 1);
        end else begin
          i_s_d_valid = 1'b0;
        end
      end
      i_m_d_ready  = md_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      i_s_a_aready = sa_rand ? 1'($urandom_range(0, 1)) : sa_force;
    end
  endtask

  initial begin
    int nlast;
    rst          = 1'b1;
    i_m_a_avalid = 1'b0;
    i_m_a_addr   = '0;
    i_m_a_len    = '0;
    i_s_a_aready = 1'b1;
    i_s_d_valid  = 1'b0;
    i_s_d_data   = '0;
    i_s_d_last   = 1'b0;
    i_m_d_ready  = 1'b1;
    sd_en = 1; sd_gap = 0; md_rand = 0; sa_rand = 0; sa_force = 1;
    fork
      bg();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ma_aready", o_m_a_aready, 1'b0);
    chk("rst_sa_avalid", o_s_a_avalid, 1'b0);
    chk("rst_md_valid", o_m_d_valid, 1'b0);
    chk("rst_sd_ready", o_s_d_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ma_aready", o_m_a_aready, 1'b1);
    chk("idle_sa_avalid", o_s_a_avalid, 1'b0);

    // 1: single aligned segment, first segment the cycle after acceptance
    send_req(32'h0000_1000, 32'd256);
    finish_phase("t1");
    chk("t1_latency", q_seg_cyc.size() > 0 ? q_seg_cyc[0] : -1, ma_cyc + 1);
    clear_obs();

    // 2: crosses one page boundary, two one-beat segments
    send_req(32'h0000_1FF0, 32'd32);
    finish_phase("t2");
    clear_obs();

    // 3: 2048 + 4096 + 4096, issued back to back
    send_req(32'h0000_0800, 32'd10240);
    finish_phase("t3");
    chk("t3_b2b_1", q_seg_cyc.size() > 2 ? q_seg_cyc[1] - q_seg_cyc[0] : -1, 1);
    chk("t3_b2b_2", q_seg_cyc.size() > 2 ? q_seg_cyc[2] - q_seg_cyc[1] : -1, 1);
    clear_obs();

    // 4: no data returned, nine one-segment requests; only eight may be outstanding
    sd_en = 0;
    for (int i = 0; i < 9; i++) send_req(32'h0001_0000 + 32'(i) * 32'h1000, 32'd64);
    repeat (10) @(negedge clk);
    chk("t4_issued", q_seg_obs.size(), 8);
    chk("t4_blocked", o_s_a_avalid, 1'b0);
    sd_en = 1;
    finish_phase("t4");
    chk("t4_unblock", (q_seg_cyc.size() > 8 && q_md_cyc.size() > 3) ? q_seg_cyc[8] - q_md_cyc[3] : -1, 1);
    clear_obs();

    // 5: random requests under random back-pressure on every channel
    sd_gap = 1; md_rand = 1; sa_rand = 1;
    for (int i = 0; i < 12; i++) begin
      send_req(32'($urandom_range(0, 32'hFFFF)) << 4, 32'(BEAT * $urandom_range(1, 512)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    finish_phase("t5");
    nlast = 0;
    foreach (q_md_last[i]) if (q_md_last[i] === 1'b1) nlast++;
    chk("t5_last_count", nlast, 12);
    sd_gap = 0; md_rand = 0; sa_rand = 0;
    clear_obs();
    repeat (3) @(posedge clk);

    // 6: reset after the first of three segments has issued
    sd_en = 0;
    send_req(32'h0000_0800, 32'd10240);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_avalid", o_s_a_avalid, 1'b1);
    chk("t6_pre_addr", o_s_a_addr, 32'h0000_1000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_avalid", o_s_a_avalid, 1'b0);
    chk("t6_md_valid", o_m_d_valid, 1'b0);
    chk("t6_sd_ready", o_s_d_ready, 1'b0);
    chk("t6_nseg", q_seg_obs.size(), 1);
    chk("t6_seg0", q_seg_obs.size() > 0 ? q_seg_obs[0] : '0, {32'h0000_0800, 32'd2048});
    clear_obs();
    sd_en = 1;
    send_req(32'h0000_1000, 32'd256);
    finish_phase("t6r");
    chk("t6r_latency", q_seg_cyc.size() > 0 ? q_seg_cyc[0] : -1, ma_cyc + 1);
    clear_obs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
